// File: rtl/radix_stage_ctrl_pkg.sv
// radix_stage_ctrl_pkg: shared state codes, output-mux selects and error bit indices for the radix-2 stage
package radix_stage_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_DRAIN} state_t;
  localparam logic [1:0] OUT_SEL_NONE = 2'b00;
  localparam logic [1:0] OUT_SEL_Y1 = 2'b01;
  localparam logic [1:0] OUT_SEL_MULT = 2'b10;
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_COL = 2;
endpackage

// File: rtl/radix_stage_ctrl_delay.sv
// valid_delay_line: 1-bit shift register delaying a valid strobe by DEPTH cycles, async reset
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  if (DEPTH == 1) begin : g_one
    // single flop when only one cycle of delay is needed
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= 1'b0;
      else q <= d;
  end else begin : g_sr
    logic [DEPTH-1:0] sr;
    // shift the strobe in at bit 0; the oldest sample leaves at the top
    always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '0;
      else sr <= {sr[DEPTH-2:0], d};
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/radix_stage_ctrl.sv
// radix_stage_ctrl: radix-2 DIF stage sequencer (y2 FIFO fill/drain, twiddle addressing, output mux); optional frame_cnt port under RADIX_STAGE_CTRL_STATS_EN
module radix_stage_ctrl
  import radix_stage_ctrl_pkg::*;
#(
  parameter int TF_NUM      = 8,
  parameter int TF_ADDR_LEN = 3,
  parameter int Y1_DELAY    = 20,
  parameter int MULT_LAT    = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bfly_valid,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   in_ready,
  output logic                   fifo_wr_en,
  output logic                   fifo_rd_en,
  output logic                   tf_en,
  output logic [TF_ADDR_LEN-1:0] tf_addr,
  output logic [1:0]             out_sel,
  output logic                   frame_done,
  output logic [2:0]             err
`ifdef RADIX_STAGE_CTRL_STATS_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);
  localparam int START_GAP = Y1_DELAY - MULT_LAT - 1;
  localparam int CW = TF_ADDR_LEN + 1;
  localparam int GW = $clog2(START_GAP + 2);
  state_t state, state_nx;
  logic [CW-1:0] fill_cnt, fill_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [TF_ADDR_LEN-1:0] addr, addr_nx;
  logic [2:0] err_nx;
  logic acc, last_wr, y1_tap, mult_tap;
  assign in_ready = state == S_IDLE || state == S_FILL;
  assign acc = bfly_valid & in_ready;
  assign fifo_wr_en = acc & ~fifo_full;
  assign fifo_rd_en = (state == S_DRAIN) & ~fifo_empty;
  assign tf_en = fifo_rd_en;
  assign tf_addr = addr;
  assign frame_done = state == S_DRAIN && addr == TF_ADDR_LEN'(TF_NUM - 1);
  assign last_wr = fifo_wr_en && (state == S_IDLE ? TF_NUM == 1 : fill_cnt == CW'(TF_NUM - 1));
  assign out_sel = mult_tap ? OUT_SEL_MULT : y1_tap ? OUT_SEL_Y1 : OUT_SEL_NONE;
  valid_delay_line #(.DEPTH(Y1_DELAY)) u_y1_dly (
    .clk (clk),
    .rst (rst),
    .d   (acc),
    .q   (y1_tap)
  );
  valid_delay_line #(.DEPTH(MULT_LAT + 1)) u_mult_dly (
    .clk (clk),
    .rst (rst),
    .d   (fifo_rd_en),
    .q   (mult_tap)
  );
  // frame sequencing: fill the y2 FIFO, wait out the y1/mult latency gap, then drain it
  always_comb begin
    state_nx = state;
    fill_nx = fill_cnt;
    gap_nx = gap;
    addr_nx = addr;
    case (state)
      S_IDLE, S_FILL: begin
        if (fifo_wr_en) fill_nx = fill_cnt + 1'b1;
        if (last_wr) begin
          fill_nx = '0;
          gap_nx = GW'(START_GAP);
          state_nx = START_GAP == 0 ? S_DRAIN : S_WAIT;
        end else if (fifo_wr_en) state_nx = S_FILL;
      end
      S_WAIT: begin
        gap_nx = gap - 1'b1;
        if (gap == GW'(1)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        addr_nx = addr + 1'b1;
        if (frame_done) begin
          addr_nx = '0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // sticky error flags: dropped write, read from empty FIFO, both mux taps at once
  always_comb begin
    err_nx = err;
    err_nx[ERR_OVF] = err[ERR_OVF] | (bfly_valid & ~fifo_wr_en);
    err_nx[ERR_UDF] = err[ERR_UDF] | ((state == S_DRAIN) & fifo_empty);
    err_nx[ERR_COL] = err[ERR_COL] | (y1_tap & mult_tap);
  end
  // state and counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      fill_cnt <= '0;
      gap <= '0;
      addr <= '0;
      err <= '0;
    end else begin
      state <= state_nx;
      fill_cnt <= fill_nx;
      gap <= gap_nx;
      addr <= addr_nx;
      err <= err_nx;
    end
`ifdef RADIX_STAGE_CTRL_STATS_EN
  // completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst)
    if (rst) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + 16'(frame_done);
`endif
endmodule

// File: tb/tb_radix_stage_ctrl.sv
// tb_radix_stage_ctrl: randomized and directed check of radix_stage_ctrl against a frame-window model
module tb_radix_stage_ctrl;
  localparam int TF_NUM = 8, Y1_DELAY = 20, MULT_LAT = 17, START_GAP = Y1_DELAY - MULT_LAT - 1, NCYC = 8192;
  logic clk = 0, rst = 1, bfly_valid = 0, fifo_full = 0, fifo_empty = 0;
  logic in_ready, fifo_wr_en, fifo_rd_en, tf_en, frame_done;
  logic [2:0] tf_addr, err;
  logic [1:0] out_sel;
  int checks = 0, errors = 0, cyc = 0;
  logic obs_rd[NCYC], obs_wr[NCYC], obs_done[NCYC];
  logic [2:0] obs_addr[NCYC];
  logic [1:0] obs_sel[NCYC];
  int fill, rd_start;
  logic [2:0] err_m;
  logic y1q[$], mq[$];
`ifdef RADIX_STAGE_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  int frames_m;
`endif
  always #5 clk = ~clk;
  radix_stage_ctrl #(.TF_NUM(TF_NUM), .TF_ADDR_LEN(3), .Y1_DELAY(Y1_DELAY), .MULT_LAT(MULT_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bfly_valid (bfly_valid),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .in_ready   (in_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .tf_en      (tf_en),
    .tf_addr    (tf_addr),
    .out_sel    (out_sel),
    .frame_done (frame_done),
    .err        (err)
`ifdef RADIX_STAGE_CTRL_STATS_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask
  function automatic void model_clear();
    fill = 0;
    rd_start = -1;
    err_m = '0;
    y1q.delete();
    mq.delete();
    for (int i = 0; i < Y1_DELAY; i++) y1q.push_back(1'b0);
    for (int i = 0; i < MULT_LAT + 1; i++) mq.push_back(1'b0);
`ifdef RADIX_STAGE_CTRL_STATS_EN
    frames_m = 0;
`endif
  endfunction
  // model: after the TF_NUM-th accepted write at cycle t, a read window opens at t+START_GAP+1 for TF_NUM cycles
  always @(negedge clk) begin : cmp
    logic ir, acc, wr, drn, rd, dn, y1, mt;
    int idx;
    if (cyc < NCYC) begin
      obs_rd[cyc] = fifo_rd_en;
      obs_wr[cyc] = fifo_wr_en;
      obs_done[cyc] = frame_done;
      obs_addr[cyc] = tf_addr;
      obs_sel[cyc] = out_sel;
    end
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_tf_en", tf_en, 0);
      chk("rst_tf_addr", tf_addr, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", err, 0);
      model_clear();
`ifdef RADIX_STAGE_CTRL_STATS_EN
      chk("rst_frame_cnt", frame_cnt, 0);
`endif
    end else begin
      ir = rd_start < 0;
      drn = rd_start >= 0 && cyc >= rd_start;
      idx = drn ? cyc - rd_start : 0;
      acc = bfly_valid & ir;
      wr = acc & ~fifo_full;
      rd = drn & ~fifo_empty;
      dn = drn && idx == TF_NUM - 1;
      y1 = y1q.pop_front();
      mt = mq.pop_front();
      chk("in_ready", in_ready, ir);
      chk("wr_en", fifo_wr_en, wr);
      chk("rd_en", fifo_rd_en, rd);
      chk("tf_en", tf_en, rd);
      chk("tf_addr", tf_addr, idx);
      chk("frame_done", frame_done, dn);
      chk("out_sel", out_sel, mt ? 2 : y1 ? 1 : 0);
      chk("err", err, err_m);
`ifdef RADIX_STAGE_CTRL_STATS_EN
      chk("frame_cnt", frame_cnt, frames_m & 16'hFFFF);
      if (dn) frames_m++;
`endif
      err_m[0] = err_m[0] | (bfly_valid & ~wr);
      err_m[1] = err_m[1] | (drn & fifo_empty);
      err_m[2] = err_m[2] | (y1 & mt);
      if (wr) begin
        fill++;
        if (fill == TF_NUM) begin
          fill = 0;
          rd_start = cyc + START_GAP + 1;
        end
      end
      if (dn) rd_start = -1;
      y1q.push_back(acc);
      mq.push_back(rd);
    end
    cyc++;
  end
  task automatic drive(input logic v, input logic f, input logic e);
    bfly_valid = v;
    fifo_full = f;
    fifo_empty = e;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask
  task automatic pulse_rst();
    bfly_valid = 0;
    fifo_full = 0;
    fifo_empty = 0;
    #1 rst = 1;
    #1;
    chk("async_rd_en", fifo_rd_en, 0);
    chk("async_tf_addr", tf_addr, 0);
    chk("async_out_sel", out_sel, 0);
    chk("async_err", err, 0);
    chk("async_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    int t, n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < TF_NUM; i++) begin
      t = cyc;
      drive(1, 0, 0);
    end
    idle(32);
    n = 0;
    for (int i = t - 7; i <= t; i++) n += obs_wr[i];
    chk("lit_wr_count", n, 8);
    chk("lit_rd_before", obs_rd[t+2], 0);
    chk("lit_rd_first", obs_rd[t+3], 1);
    chk("lit_rd_last", obs_rd[t+10], 1);
    chk("lit_rd_after", obs_rd[t+11], 0);
    chk("lit_addr_first", obs_addr[t+3], 0);
    chk("lit_addr_last", obs_addr[t+10], 7);
    chk("lit_done", obs_done[t+10], 1);
    chk("lit_done_early", obs_done[t+9], 0);
    chk("lit_sel_pre", obs_sel[t+12], 0);
    chk("lit_sel_y1_first", obs_sel[t+13], 1);
    chk("lit_sel_y1_last", obs_sel[t+20], 1);
    chk("lit_sel_mult_first", obs_sel[t+21], 2);
    chk("lit_sel_mult_last", obs_sel[t+28], 2);
    chk("lit_sel_post", obs_sel[t+29], 0);
    for (int i = 0; i < TF_NUM; i++) begin
      t = cyc;
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    idle(40);
    for (int i = 0; i < TF_NUM; i++) chk("lit_gapped_addr", obs_addr[t+3+i], i);
    chk("lit_gapped_err", err, 0);
    for (int i = 0; i < TF_NUM; i++) begin
      t = cyc;
      drive(1, 0, 0);
    end
    drive(1, 0, 0);
    idle(40);
    chk("lit_wait_wr", obs_wr[t+1], 0);
    chk("lit_ovf_sticky", err, 3'b001);
    for (int i = 0; i < TF_NUM; i++) begin
      t = cyc;
      drive(1, 0, 0);
    end
    idle(5);
    pulse_rst();
`ifdef RADIX_STAGE_CTRL_STATS_EN
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < TF_NUM; i++) drive(1, 0, 0);
      idle(START_GAP + TF_NUM);
    end
    idle(2);
    chk("lit_frame_cnt3", frame_cnt, 3);
`endif
    for (int i = 0; i < TF_NUM; i++) begin
      t = cyc;
      drive(1, 0, 0);
    end
    idle(3);
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    idle(30);
    chk("lit_udf_rd", obs_rd[t+5], 0);
    chk("lit_udf_addr_last", obs_addr[t+10], 7);
    chk("lit_udf_done", obs_done[t+10], 1);
    chk("lit_udf_err", err[1], 1);
    pulse_rst();
    for (int i = 0; i < 800; i++)
      drive(($urandom_range(0, 3) != 0) & in_ready, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    idle(40);
    pulse_rst();
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      if (i == 400) pulse_rst();
    end
    idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
